// File: rtl/riscv_dmem_track_pkg.sv
// Shared types for the data-memory request tracker: bus size encoding,
// RISC-V load/store funct3 codes and the funct3 -> bus size mapping.
package riscv_dmem_track_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HWORD = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3
    } biu_size_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // On a 32-bit core a doubleword access degrades to a word access.
    function automatic biu_size_t size_from_funct3(input logic [2:0] f3, input logic wide);
        biu_size_t sz;
        case (f3[1:0])
            2'b00:   sz = BYTE;
            2'b01:   sz = HWORD;
            2'b10:   sz = WORD;
            default: sz = wide ? DWORD : WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/riscv_dmem_track_ldext.sv
// Load data extraction: picks the addressed lane out of the bus word and
// sign- or zero-extends it according to the load funct3.
module riscv_dmem_track_ldext
    import riscv_dmem_track_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                  funct3_i,
    input  logic [$clog2(XLEN/8)-1:0]   lane_i,
    input  logic [XLEN-1:0]             q_i,
    output logic [XLEN-1:0]             r_o
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] word_ext;
    logic            sx;

    assign shifted = q_i >> {lane_i, 3'b000};
    assign sx      = ~funct3_i[2];

    // A 32-bit word already fills a 32-bit register, so LWU acts like LW there.
    if (XLEN > 32) begin : g_word_wide
        assign word_ext = {{(XLEN-32){sx & shifted[31]}}, shifted[31:0]};
    end else begin : g_word_narrow
        assign word_ext = shifted;
    end

    always_comb begin
        r_o = shifted;
        case (funct3_i)
            F3_LB, F3_LBU: r_o = {{(XLEN-8){sx & shifted[7]}}, shifted[7:0]};
            F3_LH, F3_LHU: r_o = {{(XLEN-16){sx & shifted[15]}}, shifted[15:0]};
            F3_LW, F3_LWU: r_o = word_ext;
            F3_LD:         r_o = shifted;
            default:       r_o = shifted;
        endcase
    end

endmodule

// File: rtl/riscv_dmem_track.sv
// In-order outstanding data-memory request tracker between MEM and WB:
// issues bus requests, queues their context, matches acks and retires to WB.
module riscv_dmem_track
    import riscv_dmem_track_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_adr_i,
    input  logic [XLEN-1:0] req_d_i,
    input  logic [4:0]      req_dst_i,
    input  logic [XLEN-1:0] req_pc_i,
    input  logic            flush_i,
    output logic            dmem_req_o,
    output logic [XLEN-1:0] dmem_adr_o,
    output logic [XLEN-1:0] dmem_d_o,
    output logic            dmem_we_o,
    output logic [2:0]      dmem_size_o,
    input  logic            dmem_ack_i,
    input  logic            dmem_err_i,
    input  logic [XLEN-1:0] dmem_q_i,
    output logic            wb_valid_o,
    output logic            wb_we_o,
    output logic [4:0]      wb_dst_o,
    output logic [XLEN-1:0] wb_r_o,
    output logic [XLEN-1:0] wb_pc_o,
    output logic            wb_err_o,
    output logic [XLEN-1:0] wb_badaddr_o,
    output logic            busy_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LANE_W = $clog2(XLEN/8);

    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [XLEN-1:0] adr;
        logic [4:0]      dst;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [DEPTH-1:0]  kill_q, kill_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    logic              wb_valid_q, wb_valid_d, wb_we_q, wb_we_d, wb_err_q, wb_err_d;
    logic [4:0]        wb_dst_q, wb_dst_d;
    logic [XLEN-1:0]   wb_r_q, wb_r_d, wb_pc_q, wb_pc_d, wb_badaddr_q, wb_badaddr_d;

    logic              issue, ack_take, retire, head_kill;
    entry_t            head;
    logic [XLEN-1:0]   ext_r;

    // count never exceeds DEPTH (a power of two), so its MSB alone flags "full".
    assign req_ready_o = ~count_q[PTR_W] & ~flush_i;
    assign issue       = req_valid_i & req_ready_o;
    assign dmem_req_o  = issue;
    assign dmem_adr_o  = req_adr_i;
    assign dmem_d_o    = req_d_i;
    assign dmem_we_o   = req_we_i;
    assign dmem_size_o = size_from_funct3(req_funct3_i, XLEN == 64);
    assign busy_o      = count_q != '0;

    assign head      = mem_q[rd_ptr_q];
    assign ack_take  = dmem_ack_i & (count_q != '0);
    // An ack landing in the flush cycle belongs to a killed entry as well.
    assign head_kill = kill_q[rd_ptr_q] | flush_i;
    assign retire    = ack_take & ~head_kill;

    riscv_dmem_track_ldext #(.XLEN(XLEN)) u_ldext (
        .funct3_i (head.funct3),
        .lane_i   (head.adr[LANE_W-1:0]),
        .q_i      (dmem_q_i),
        .r_o      (ext_r)
    );

    always_comb begin
        mem_d    = mem_q;
        kill_d   = flush_i ? {DEPTH{1'b1}} : kill_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(issue);
        rd_ptr_d = rd_ptr_q + PTR_W'(ack_take);
        count_d  = count_q + (PTR_W+1)'(issue) - (PTR_W+1)'(ack_take);
        if (issue) begin
            mem_d[wr_ptr_q]  = '{we: req_we_i, funct3: req_funct3_i, adr: req_adr_i,
                                 dst: req_dst_i, pc: req_pc_i};
            kill_d[wr_ptr_q] = 1'b0;
        end
    end

    always_comb begin
        wb_valid_d   = retire;
        wb_we_d      = retire & ~dmem_err_i & ~head.we & (head.dst != 5'd0);
        wb_err_d     = retire & dmem_err_i;
        wb_dst_d     = retire ? head.dst : wb_dst_q;
        wb_pc_d      = retire ? head.pc : wb_pc_q;
        wb_r_d       = wb_r_q;
        wb_badaddr_d = wb_badaddr_q;
        if (retire) begin
            wb_r_d = (head.we | dmem_err_i) ? '0 : ext_r;
            if (dmem_err_i) wb_badaddr_d = head.adr;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            kill_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_err_q     <= 1'b0;
            wb_dst_q     <= '0;
            wb_r_q       <= '0;
            wb_pc_q      <= '0;
            wb_badaddr_q <= '0;
        end else begin
            kill_q       <= kill_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_err_q     <= wb_err_d;
            wb_dst_q     <= wb_dst_d;
            wb_r_q       <= wb_r_d;
            wb_pc_q      <= wb_pc_d;
            wb_badaddr_q <= wb_badaddr_d;
        end
    end

    assign wb_valid_o   = wb_valid_q;
    assign wb_we_o      = wb_we_q;
    assign wb_err_o     = wb_err_q;
    assign wb_dst_o     = wb_dst_q;
    assign wb_r_o       = wb_r_q;
    assign wb_pc_o      = wb_pc_q;
    assign wb_badaddr_o = wb_badaddr_q;

endmodule

// File: tb/tb_riscv_dmem_track.sv
// Bench for riscv_dmem_track (XLEN=32, DEPTH=4): directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_riscv_dmem_track;
    import riscv_dmem_track_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0, req_we_i = 1'b0, flush_i = 1'b0;
    logic [2:0]  req_funct3_i = '0;
    logic [31:0] req_adr_i = '0, req_d_i = '0, req_pc_i = '0, dmem_q_i = '0;
    logic [4:0]  req_dst_i = '0;
    logic        dmem_ack_i = 1'b0, dmem_err_i = 1'b0;
    logic        req_ready_o, dmem_req_o, dmem_we_o, wb_valid_o, wb_we_o, wb_err_o, busy_o;
    logic [31:0] dmem_adr_o, dmem_d_o, wb_r_o, wb_pc_o, wb_badaddr_o;
    logic [2:0]  dmem_size_o;
    logic [4:0]  wb_dst_o;

    riscv_dmem_track #(.XLEN(32), .DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_funct3_i(req_funct3_i), .req_adr_i(req_adr_i), .req_d_i(req_d_i),
        .req_dst_i(req_dst_i), .req_pc_i(req_pc_i), .flush_i(flush_i),
        .dmem_req_o(dmem_req_o), .dmem_adr_o(dmem_adr_o), .dmem_d_o(dmem_d_o),
        .dmem_we_o(dmem_we_o), .dmem_size_o(dmem_size_o),
        .dmem_ack_i(dmem_ack_i), .dmem_err_i(dmem_err_i), .dmem_q_i(dmem_q_i),
        .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_dst_o(wb_dst_o), .wb_r_o(wb_r_o),
        .wb_pc_o(wb_pc_o), .wb_err_o(wb_err_o), .wb_badaddr_o(wb_badaddr_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          we;
        logic [2:0]  f3;
        logic [31:0] adr;
        logic [4:0]  dst;
        logic [31:0] pc;
        bit          kill;
    } mentry_t;

    mentry_t     mq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_r = '0;
    bit          r_known = 1'b1;
    int          wb_count = 0;

    // stimulus for the next cycle
    bit          s_req, s_we, s_flush, s_ack, s_err;
    logic [2:0]  s_f3;
    logic [31:0] s_adr, s_d, s_pc, s_q;
    logic [4:0]  s_dst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference load extension: shift the addressed byte lane down, mask, then extend.
    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] adr,
                                        input logic [31:0] q);
        logic [31:0] v;
        v = q >> (8 * adr[1:0]);
        case (f3[1:0])
            2'b00: begin
                v = v & 32'hFF;
                if (!f3[2] && v >= 32'h80) v = v + 32'hFFFF_FF00;
            end
            2'b01: begin
                v = v & 32'hFFFF;
                if (!f3[2] && v >= 32'h8000) v = v + 32'hFFFF_0000;
            end
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] exp_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b11) ? 3'd2 : {1'b0, f3[1:0]};
    endfunction

    task automatic idle();
        s_req = 0; s_we = 0; s_flush = 0; s_ack = 0; s_err = 0;
        s_f3 = '0; s_adr = '0; s_d = '0; s_pc = '0; s_q = '0; s_dst = '0;
    endtask

    task automatic set_req(input bit we, input logic [2:0] f3, input logic [31:0] adr,
                           input logic [31:0] pc, input logic [4:0] dst);
        s_req = 1; s_we = we; s_f3 = f3; s_adr = adr; s_pc = pc; s_dst = dst;
        s_d = $urandom;
    endtask

    task automatic set_ack(input bit err, input logic [31:0] q);
        s_ack = 1; s_err = err; s_q = q;
    endtask

    task automatic step();
        bit          exp_ready, exp_issue, exp_ret;
        mentry_t     h;
        logic [31:0] r;
        @(negedge clk_i);
        req_valid_i = s_req; req_we_i = s_we; req_funct3_i = s_f3; req_adr_i = s_adr;
        req_d_i = s_d; req_dst_i = s_dst; req_pc_i = s_pc; flush_i = s_flush;
        dmem_ack_i = s_ack; dmem_err_i = s_err; dmem_q_i = s_q;
        #1;
        exp_ready = (mq.size() < 4) && !s_flush;
        exp_issue = s_req && exp_ready;
        chk("req_ready", req_ready_o, exp_ready);
        chk("dmem_req", dmem_req_o, exp_issue);
        chk("busy", busy_o, mq.size() != 0);
        if (exp_issue) begin
            chk("dmem_adr", dmem_adr_o, s_adr);
            chk("dmem_we", dmem_we_o, s_we);
            chk("dmem_d", dmem_d_o, s_d);
            chk("dmem_size", dmem_size_o, exp_size(s_f3));
        end
        if (s_flush) foreach (mq[i]) mq[i].kill = 1;
        exp_ret = 0;
        if (s_ack && mq.size() > 0) begin
            h = mq.pop_front();
            exp_ret = !h.kill;
        end
        if (exp_issue) mq.push_back('{s_we, s_f3, s_adr, s_dst, s_pc, 1'b0});
        @(posedge clk_i);
        #1;
        chk("wb_valid", wb_valid_o, exp_ret);
        if (exp_ret) begin
            wb_count++;
            chk("wb_pc", wb_pc_o, h.pc);
            chk("wb_err", wb_err_o, s_err);
            chk("wb_we", wb_we_o, !s_err && !h.we && h.dst != 0);
            chk("wb_dst", wb_dst_o, h.dst);
            if (s_err) begin
                chk("wb_badaddr", wb_badaddr_o, h.adr);
                r_known = 0;
            end else begin
                r = h.we ? 32'd0 : ext(h.f3, h.adr, s_q);
                chk("wb_r", wb_r_o, r);
                last_r = r; r_known = 1;
            end
        end else begin
            chk("wb_we_idle", wb_we_o, 1'b0);
            chk("wb_err_idle", wb_err_o, 1'b0);
            if (r_known) chk("wb_r_hold", wb_r_o, last_r);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1; req_valid_i = 0; dmem_ack_i = 0; flush_i = 0;
        #1;
        chk("rst_wb_valid", wb_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_wb_r", wb_r_o, 32'd0);
        @(negedge clk_i);
        rst_i = 0;
        #1;
        chk("rst_ready", req_ready_o, 1'b1);
        chk("rst_busy2", busy_o, 1'b0);
        mq.delete();
        last_r = '0; r_known = 1;
    endtask

    initial begin
        int n;
        idle();
        do_reset();

        // LB / LBU on the top byte lane
        set_req(0, F3_LB, 32'h1003, 32'h100, 5'd3); step();
        idle(); set_ack(0, 32'h80FF_FF00); step();
        idle(); set_req(0, F3_LBU, 32'h1003, 32'h104, 5'd4); step();
        idle(); set_ack(0, 32'h80FF_FF00); step();
        idle(); step();
        chk("lb_lbu_retired", wb_r_o, 32'h0000_0080);

        // Fill the queue, fifth request refused, single ack frees a slot one cycle later
        for (int i = 0; i < 5; i++) begin
            idle(); set_req(0, F3_LW, 32'h3000 + 4*i, 32'hA00 + 4*i, 5'(i + 1)); step();
        end
        idle(); set_req(0, F3_LH, 32'h3012, 32'hB00, 5'd9); set_ack(0, 32'h1234_5678); step();
        idle(); set_req(0, F3_LH, 32'h3012, 32'hB00, 5'd9); step();
        for (int i = 0; i < 4; i++) begin
            idle(); set_ack(0, $urandom); step();
        end
        idle(); step();

        // Flush with three outstanding: their acks drain silently
        for (int i = 0; i < 3; i++) begin
            idle(); set_req(0, F3_LW, 32'h4000 + 4*i, 32'hC00 + 4*i, 5'd7); step();
        end
        idle(); s_flush = 1; set_req(0, F3_LW, 32'h5000, 32'hD00, 5'd8); step();
        n = wb_count;
        for (int i = 0; i < 3; i++) begin
            idle(); set_ack(0, $urandom); step();
        end
        chk("flush_no_retire", wb_count, n);
        idle(); set_req(0, F3_LHU, 32'h5002, 32'hE00, 5'd5); step();
        idle(); set_ack(0, 32'hBEEF_0000); step();
        idle(); step();

        // Store completing with a bus error
        idle(); set_req(1, F3_LW, 32'h2004, 32'hF00, 5'd0); step();
        idle(); set_ack(1, 32'h0); step();
        idle(); step();

        // Spurious ack, then request+ack together at count 2
        idle(); set_ack(0, 32'hFFFF_FFFF); step();
        idle(); set_req(0, F3_LB, 32'h6000, 32'h1000, 5'd1); step();
        idle(); set_req(0, F3_LB, 32'h6001, 32'h1004, 5'd2); step();
        idle(); set_req(0, F3_LB, 32'h6002, 32'h1008, 5'd3); set_ack(0, 32'h0000_7F80); step();
        chk("busy_count2", mq.size(), 2);
        for (int i = 0; i < 2; i++) begin
            idle(); set_ack(0, 32'h00C3_0000); step();
        end
        idle(); step();

        // Reset while requests are outstanding
        idle(); set_req(0, F3_LW, 32'h7000, 32'h1100, 5'd6); step();
        idle(); set_req(1, F3_LH, 32'h7002, 32'h1104, 5'd0); step();
        do_reset();
        idle(); set_ack(0, 32'h1); step();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            logic [2:0] f3;
            idle();
            if ($urandom_range(99) < 60) begin
                if ($urandom_range(1) == 1) begin
                    f3 = 3'($urandom_range(2));
                    set_req(1, f3, $urandom, $urandom, 5'd0);
                end else begin
                    f3 = 3'($urandom_range(6));
                    set_req(0, f3, $urandom, $urandom, 5'($urandom));
                end
            end
            if (mq.size() > 0 ? ($urandom_range(99) < 50) : ($urandom_range(99) < 5))
                set_ack($urandom_range(9) == 0, $urandom);
            if ($urandom_range(99) < 4) s_flush = 1;
            step();
        end
        idle();
        while (mq.size() > 0) begin
            idle(); set_ack(0, $urandom); step();
        end
        idle(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
